instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Producer side of the IF/ID boundary: generates the fetch PC, issues single-outstanding reads to instruction memory, and buffers returned instructions in a 2-entry queue. It presents the head entry (instruction, PC, PC+4, prediction bit) to the IF/ID pipeline register, which latches it on every non-stalled clock. A 16-entry BTB with 2-bit counters steers the fetch PC and is trained by branch resolution from later stages.

## Interface
- RESET_PC, 32'hBFC00000, fetch PC after reset
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- STALL  in  1  consumer frozen; head entry not consumed
- FLUSH  in  1  redirect: discard queue and in-flight fetch, restart at REDIRECT_PC
- REDIRECT_PC  in  32  restart address, valid with FLUSH
- Instr1_IF  out  32  head instruction (0 = NOP bubble when empty)
- Instr_PC_IF  out  32  head PC (0 when empty)
- Instr_PC_Plus4_IF  out  32  head PC+4 (0 when empty)
- Branch_prediction_IF  out  1  head predicted-taken (0 when empty)
- IMEM_REQ  out  1  read request valid
- IMEM_ADDR  out  32  read address, word-aligned
- IMEM_ACK  in  1  request accepted this cycle
- IMEM_RVALID  in  1  read data valid
- IMEM_RDATA  in  32  read data
- BR_UPDATE  in  1  resolved-branch update strobe
- BR_UPDATE_PC  in  32  PC of resolved branch
- BR_TAKEN  in  1  resolved direction
- BR_TARGET  in  32  resolved target

## Operation
- Fetch FSM: REQ (IMEM_REQ=1, IMEM_ADDR=fetch PC), WAIT (awaiting RVALID), HOLD (no credit).
- Credit: a request is issued only when queue count + outstanding < 2; otherwise HOLD. HOLD->REQ when an entry is consumed.
- REQ->WAIT on ACK; fetch PC, PC+4 and prediction for that address are captured into an in-flight register; next fetch PC = predicted taken ? BTB target : PC+4.
- WAIT->REQ (or HOLD if no credit) on RVALID; entry {RDATA, PC, PC+4, pred} written to queue tail.
- Consume: at a rising edge with STALL=0 and queue non-empty, head is popped. STALL=1: no pop, head held.
- Empty queue: outputs all zero (bubble); nothing popped.
- BTB lookup (combinational on fetch PC): index PC[5:2], tag PC[31:6]; hit && counter>=2 -> taken.
- BTB update on BR_UPDATE: tag hit -> counter saturating inc (taken) / dec (not taken), target <- BR_TARGET if taken; miss && taken -> allocate, counter=2, target written; miss && not taken -> no change.
- FLUSH (priority over all): queue emptied, fetch PC <- REDIRECT_PC, FSM -> REQ; if in WAIT, drop flag set and the next RVALID is discarded (FSM stays idle until it arrives, then REQ). FLUSH during REQ without ACK: address switches to REDIRECT_PC next cycle. BTB updates still applied during FLUSH.
- Reset: fetch PC=RESET_PC, queue empty, FSM=REQ, drop flag 0, all BTB valid=0, counters=1, all outputs 0.
- PC arithmetic modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.

## Timing
- First IMEM_REQ asserted the first cycle after RESET deasserts.
- IMEM_ADDR/IMEM_REQ stable while REQ and ACK=0.
- Entry visible on outputs the cycle after its RVALID edge.
- Zero-latency memory (ACK in REQ cycle, RVALID next): one instruction per 2 cycles.
- Same-cycle BTB lookup and update to one index: lookup sees pre-update state.
- Same-cycle RVALID and pop: both occur; count unchanged.

## Test plan
- Reset, memory ACK immediate, RVALID +1: IMEM_ADDR sequence BFC00000, BFC00004, BFC00008; outputs show each instr with correct PC/PC+4, pred 0.
- STALL high 5 cycles with memory ready: queue fills to 2, IMEM_REQ drops (HOLD), head unchanged; release -> entries emerge in order, none lost/duplicated.
- FLUSH with REDIRECT_PC=00400000 while in WAIT: late RVALID discarded, outputs 0 next cycle, next IMEM_ADDR=00400000.
- BR_UPDATE PC=BFC00008 taken target=BFC00100: later fetch at BFC00008 yields pred 1 and next IMEM_ADDR=BFC00100; two not-taken updates -> pred 0, next addr BFC0000C.
- ACK delayed 3 cycles, RVALID delayed 4: address held stable, single outstanding request, outputs 0 while empty.
- RESET asserted mid-WAIT with full queue: outputs 0 immediately, BTB cleared, restart at BFC00000.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: single-outstanding request/accept handshake
// followed by a read-data strobe.
interface instr_fetch_unit_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;

  modport master (output IMEM_REQ, IMEM_ADDR, input IMEM_ACK, IMEM_RVALID, IMEM_RDATA);
  modport slave  (input IMEM_REQ, IMEM_ADDR, output IMEM_ACK, IMEM_RVALID, IMEM_RDATA);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, single-outstanding IMEM reads, 2-entry return
// queue feeding IF/ID, and a 16-entry direct-mapped BTB with 2-bit counters.

module btb_entry (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        sel,
  input  logic        taken,
  input  logic [25:0] upd_tag,
  input  logic [31:0] target,
  output logic        v,
  output logic [25:0] tag,
  output logic [1:0]  ctr,
  output logic [31:0] tgt
);
  logic hit;
  assign hit = v && (tag == upd_tag);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      v   <= 1'b0;
      tag <= '0;
      ctr <= 2'd1;
      tgt <= '0;
    end else if (sel) begin
      if (hit) begin
        if (taken) begin
          tgt <= target;
          if (ctr != 2'd3) ctr <= ctr + 2'd1;
        end else if (ctr != 2'd0) begin
          ctr <= ctr - 2'd1;
        end
      end else if (taken) begin
        v   <= 1'b1;
        tag <= upd_tag;
        ctr <= 2'd2;
        tgt <= target;
      end
    end
  end
endmodule

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] Instr1_IF,
  output logic [31:0] Instr_PC_IF,
  output logic [31:0] Instr_PC_Plus4_IF,
  output logic        Branch_prediction_IF,
  instr_fetch_unit_if.master imem,
  input  logic        BR_UPDATE,
  input  logic [31:0] BR_UPDATE_PC,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET
);
  localparam int BTB_N = 16;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  state_t      state, nxt_state;
  logic        drop, nxt_drop;
  logic [31:0] fetch_pc, infl_pc;
  logic        infl_pred;
  logic [1:0]  count, cnt_after;
  entry_t      q0, q1, new_ent;
  logic        push, pop, acked;

  logic [BTB_N-1:0]       e_v;
  logic [BTB_N-1:0][25:0] e_tag;
  logic [BTB_N-1:0][1:0]  e_ctr;
  logic [BTB_N-1:0][31:0] e_tgt;
  logic [3:0]  lk_idx;
  logic        pred;
  logic [31:0] pred_tgt;
  logic        unused_bits;

  for (genvar i = 0; i < BTB_N; i++) begin : g_btb
    btb_entry u_ent (
      .CLK    (CLK),
      .RESET  (RESET),
      .sel    (BR_UPDATE && (BR_UPDATE_PC[5:2] == 4'(i))),
      .taken  (BR_TAKEN),
      .upd_tag(BR_UPDATE_PC[31:6]),
      .target (BR_TARGET),
      .v      (e_v[i]),
      .tag    (e_tag[i]),
      .ctr    (e_ctr[i]),
      .tgt    (e_tgt[i])
    );
  end

  // Lookup reads the registered BTB, so a same-cycle update is not visible yet.
  assign lk_idx   = fetch_pc[5:2];
  assign pred     = e_v[lk_idx] && (e_tag[lk_idx] == fetch_pc[31:6]) && (e_ctr[lk_idx] >= 2'd2);
  assign pred_tgt = e_tgt[lk_idx];
  assign unused_bits = &{1'b0, BR_UPDATE_PC[1:0]};

  assign acked     = (state == S_REQ) && imem.IMEM_ACK;
  assign push      = (state == S_WAIT) && imem.IMEM_RVALID && !drop;
  assign pop       = !STALL && (count != 2'd0);
  assign cnt_after = count + {1'b0, push} - {1'b0, pop};
  assign new_ent   = '{instr: imem.IMEM_RDATA, pc: infl_pc, pred: infl_pred};

  always_comb begin
    nxt_state = state;
    nxt_drop  = drop;
    unique case (state)
      S_REQ:  if (imem.IMEM_ACK) nxt_state = S_WAIT;
      S_WAIT: if (imem.IMEM_RVALID) begin
        nxt_drop  = 1'b0;
        nxt_state = (drop || cnt_after < 2'd2) ? S_REQ : S_HOLD;
      end
      S_HOLD: if (pop) nxt_state = S_REQ;
      default: nxt_state = S_REQ;
    endcase
    // A request already accepted (or accepted this very cycle) must be
    // drained and thrown away before the redirected fetch can go out.
    if (FLUSH) begin
      if ((state == S_WAIT && !imem.IMEM_RVALID) || acked) begin
        nxt_state = S_WAIT;
        nxt_drop  = 1'b1;
      end else begin
        nxt_state = S_REQ;
        nxt_drop  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_REQ;
      drop      <= 1'b0;
      fetch_pc  <= RESET_PC;
      infl_pc   <= '0;
      infl_pred <= 1'b0;
      count     <= 2'd0;
      q0        <= '0;
      q1        <= '0;
    end else begin
      state <= nxt_state;
      drop  <= nxt_drop;
      if (FLUSH) begin
        fetch_pc <= REDIRECT_PC;
        count    <= 2'd0;
      end else begin
        if (acked) begin
          infl_pc   <= fetch_pc;
          infl_pred <= pred;
          fetch_pc  <= pred ? pred_tgt : fetch_pc + 32'd4;
        end
        count <= cnt_after;
        unique case ({push, pop})
          2'b01: q0 <= q1;
          2'b10: if (count == 2'd0) q0 <= new_ent; else q1 <= new_ent;
          2'b11: if (count == 2'd1) q0 <= new_ent;
                 else begin q0 <= q1; q1 <= new_ent; end
          default: ;
        endcase
      end
    end
  end

  // Request is masked while reset is held so every output reads 0.
  assign imem.IMEM_REQ  = RESET && (state == S_REQ);
  assign imem.IMEM_ADDR = imem.IMEM_REQ ? {fetch_pc[31:2], 2'b00} : '0;

  assign Instr1_IF            = (count != 2'd0) ? q0.instr : '0;
  assign Instr_PC_IF          = (count != 2'd0) ? q0.pc : '0;
  assign Instr_PC_Plus4_IF    = (count != 2'd0) ? q0.pc + 32'd4 : '0;
  assign Branch_prediction_IF = (count != 2'd0) && q0.pred;
endmodule
